// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding for the bit-serial adder sequencer
package serial_add_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell (a + b + c -> Carry,Sum)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic Sum,
  output logic Carry
);
  assign Sum   = a ^ b ^ c;
  assign Carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, one full_adder, valid/ready on both sides
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op_a, op_b, cin (operand side);
//        op_sub (only with SERIAL_ADD_SUB_EN); out_valid/out_ready, sum, cout (result side);
//        busy (RUN or DONE). SERIAL_ADD_SUB_EN enables subtraction (sum = a - b, cout = no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
  logic [CNT_W-1:0] cnt;
  logic carry, carry_ld, b_bit, fa_s, fa_c, accept, last;
`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;
  // subtraction is a + ~b + 1: invert B on the fly and seed the carry with 1
  assign b_bit    = b_sr[0] ^ sub_r;
  assign carry_ld = op_sub | cin;
`else
  assign b_bit    = b_sr[0];
  assign carry_ld = cin;
`endif
  full_adder u_fa (.a(a_sr[0]), .b(b_bit), .c(carry), .Sum(fa_s), .Carry(fa_c));
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  assign sum       = sum_sr;
  assign cout      = carry;
  assign accept    = in_valid & in_ready;
  assign last      = cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    sum_nx = sum_sr >> 1;
    sum_nx[WIDTH-1] = fa_s;
    state_nx = (state == S_IDLE && in_valid) ? S_RUN  :
               (state == S_RUN  && last)     ? S_DONE :
               (state == S_DONE && out_ready) ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr  <= op_a;
        b_sr  <= op_b;
        carry <= carry_ld;
        cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
        sub_r <= op_sub;
`endif
      end else if (state == S_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_nx;
        carry  <= fa_c;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end
endmodule
